bus_burst_responder: RTL and testbench

Memory-mapped burst responder (bus slave) on the shared system bus. It answers burst reads and writes from bus initiators such as the DMA engine of the RAM/DMA custom instruction. It holds a local word-addressed SRAM, decodes its own address window, and drives the responder-side handshake: data_valid, end_transaction, busy and error. All outputs are zero when the block is not selected, so they can be OR-combined onto the bus.

---
 rtl/bus_burst_responder.sv | 167 ++++++++++++++++
 tb/tb_bus_burst_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_burst_responder.sv
// Burst read/write responder with a local word-addressed SRAM behind an address window.
// Outputs are all zero unless this block owns the current transaction, so they can be OR-combined.
module bus_burst_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          DEPTH_LOG2   = 9,
  parameter int          READ_WAIT    = 1,
  parameter int          BUSY_EVERY   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        busIn_begin_transaction,
  input  logic [31:0] busIn_address_data,
  input  logic        busIn_read_n_write,
  input  logic [7:0]  busIn_burst_size,
  input  logic [3:0]  busIn_byte_enables,
  input  logic        busIn_data_valid,
  input  logic        busIn_end_transaction,
  output logic [31:0] busOut_address_data,
  output logic        busOut_data_valid,
  output logic        busOut_end_transaction,
  output logic        busOut_busy,
  output logic        busOut_error
);

  // state   | meaning
  // IDLE    | waiting for a begin_transaction that hits the window
  // RD_WAIT | read accepted, counting wait cycles while the RAM prefetches
  // RD_DATA | one read beat on the bus per cycle
  // RD_END  | end_transaction pulse after the last read beat
  // WR_DATA | accepting write beats until the initiator ends the burst
  // ERR     | one-cycle error pulse for a burst that runs past the window
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, RD_END, WR_DATA, ERR} state_t;

  localparam int SW = ((DEPTH_LOG2 > 8) ? DEPTH_LOG2 : 8) + 1;
  localparam int BW = 16;
  localparam logic [SW-1:0] DEPTH_WORDS = SW'(1) << DEPTH_LOG2;

  state_t                state;
  logic [DEPTH_LOG2-1:0] idx;
  logic [8:0]            rem;
  logic [3:0]            be_q;
  logic [7:0]            wcnt;
  logic [BW-1:0]         bcnt;
  logic                  valid_q;
  logic                  end_q;
  logic                  busy_q;
  logic                  err_q;
  logic [31:0]           rd_word;

  logic [31:0]           offset;
  logic                  sel;
  logic [DEPTH_LOG2-1:0] start_idx;
  logic [SW-1:0]         end_sum;
  logic                  past_end;
  logic                  wr_accept;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  assign offset    = busIn_address_data - BASE_ADDRESS;
  assign sel       = (busIn_address_data >= BASE_ADDRESS) && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign start_idx = offset[DEPTH_LOG2+1:2];
  assign end_sum   = SW'(start_idx) + SW'(busIn_burst_size);
  assign past_end  = end_sum >= DEPTH_WORDS;

  // For writes rem counts beats still allowed, so zero means further beats are dropped.
  assign wr_accept = (state == WR_DATA) && busIn_data_valid && !busy_q &&
                     !busIn_end_transaction && (rem != 9'd0);

  always_ff @(posedge clock) begin
    if (wr_accept) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx][8*b +: 8] <= busIn_address_data[8*b +: 8];
      end
    end
    rd_word <= mem[idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      rem     <= '0;
      be_q    <= '0;
      wcnt    <= '0;
      bcnt    <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      end_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      case (state)
        IDLE: begin
          if (busIn_begin_transaction && sel) begin
            idx  <= start_idx;
            be_q <= busIn_byte_enables;
            wcnt <= 8'(READ_WAIT - 1);
            bcnt <= '0;
            if (past_end) begin
              state <= ERR;
              err_q <= 1'b1;
            end else if (busIn_read_n_write) begin
              state <= RD_WAIT;
              rem   <= {1'b0, busIn_burst_size};
            end else begin
              state <= WR_DATA;
              rem   <= {1'b0, busIn_burst_size} + 9'd1;
            end
          end
        end
        RD_WAIT: begin
          if (busIn_end_transaction) begin
            state <= IDLE;
          end else if (wcnt == 8'd0) begin
            // rd_word already holds mem[idx]; step the address for the next beat
            state   <= RD_DATA;
            valid_q <= 1'b1;
            idx     <= idx + 1'b1;
          end else begin
            wcnt <= wcnt - 8'd1;
          end
        end
        RD_DATA: begin
          if (busIn_end_transaction) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end else if (rem == 9'd0) begin
            state   <= RD_END;
            valid_q <= 1'b0;
            end_q   <= 1'b1;
          end else begin
            rem <= rem - 9'd1;
            idx <= idx + 1'b1;
          end
        end
        RD_END: state <= IDLE;
        WR_DATA: begin
          if (busIn_end_transaction) begin
            state <= IDLE;
          end else if (wr_accept) begin
            idx <= idx + 1'b1;
            rem <= rem - 9'd1;
            if (BUSY_EVERY > 0) begin
              if (bcnt == BW'(BUSY_EVERY - 1)) begin
                bcnt   <= '0;
                busy_q <= 1'b1;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busOut_address_data    = rd_word & {32{valid_q}};
  assign busOut_data_valid      = valid_q;
  assign busOut_end_transaction = end_q;
  assign busOut_busy            = busy_q;
  assign busOut_error           = err_q;

endmodule

// File: tb/tb_bus_burst_responder.sv
// Scoreboard bench for bus_burst_responder: stimulus queues cycle-stamped expected events,
// a negedge monitor matches every observed output event against the queue.
module tb_bus_burst_responder;

  localparam int KD = 1;  // read data beat
  localparam int KE = 2;  // end_transaction
  localparam int KR = 3;  // error
  localparam int KB = 4;  // busy

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        busIn_begin_transaction;
  logic [31:0] busIn_address_data;
  logic        busIn_read_n_write;
  logic [7:0]  busIn_burst_size;
  logic [3:0]  busIn_byte_enables;
  logic        busIn_data_valid;
  logic        busIn_end_transaction;
  logic [31:0] busOut_address_data;
  logic        busOut_data_valid;
  logic        busOut_end_transaction;
  logic        busOut_busy;
  logic        busOut_error;

  bus_burst_responder #(
    .BASE_ADDRESS(32'h0000_0000),
    .DEPTH_LOG2  (9),
    .READ_WAIT   (1),
    .BUSY_EVERY  (4)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .busIn_begin_transaction(busIn_begin_transaction),
    .busIn_address_data    (busIn_address_data),
    .busIn_read_n_write    (busIn_read_n_write),
    .busIn_burst_size      (busIn_burst_size),
    .busIn_byte_enables    (busIn_byte_enables),
    .busIn_data_valid      (busIn_data_valid),
    .busIn_end_transaction (busIn_end_transaction),
    .busOut_address_data   (busOut_address_data),
    .busOut_data_valid     (busOut_data_valid),
    .busOut_end_transaction(busOut_end_transaction),
    .busOut_busy           (busOut_busy),
    .busOut_error          (busOut_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] data;
    bit          opt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_mem [512];
  logic [31:0] wdata [16];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  task automatic observe(int kind, logic [31:0] data);
    exp_t e;
    while (sb.size() > 0 && sb[0].opt && sb[0].cyc < cyc) void'(sb.pop_front());
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind %0d data %h at cycle %0d, required none", kind, data, cyc);
    end else begin
      e = sb.pop_front();
      check("bus_event", {4'(kind), 28'(cyc), data}, {4'(e.kind), 28'(e.cyc), e.data});
    end
  endtask

  task automatic expire();
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (!e.opt) begin
        n_checks++;
        $display("FAIL missing_event: got nothing, required kind %0d data %h at cycle %0d", e.kind, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clock) begin
    if (busOut_data_valid)      observe(KD, busOut_address_data);
    if (busOut_end_transaction) observe(KE, 32'd0);
    if (busOut_error)           observe(KR, 32'd0);
    if (busOut_busy)            observe(KB, 32'd0);
    if (!busOut_data_valid)     check("idle_data_zero", 64'(busOut_address_data), 64'd0);
    expire();
  end

  task automatic push(int kind, int c, logic [31:0] d, bit opt);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    e.opt  = opt;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    busIn_begin_transaction = 1'b0;
    busIn_address_data      = '0;
    busIn_read_n_write      = 1'b0;
    busIn_burst_size        = '0;
    busIn_byte_enables      = '0;
    busIn_data_valid        = 1'b0;
    busIn_end_transaction   = 1'b0;
  endtask

  task automatic check_outputs_zero(string name);
    check(name, 64'({busOut_data_valid, busOut_end_transaction, busOut_busy, busOut_error, busOut_address_data}), 64'd0);
  endtask

  // Writes wdata[0..nsend-1]; with end_last the final beat carries end_transaction and must be dropped.
  task automatic do_write(int addr, int burst_n, int nsend, bit end_last, logic [3:0] be_v);
    bit sel;
    bit err;
    int idx;
    int cnt;
    bit accepted;
    sel = (addr < 2048);
    idx = (addr >> 2) & 511;
    err = sel && (idx + burst_n >= 512);
    tick();
    busIn_begin_transaction = 1'b1;
    busIn_address_data      = 32'(addr);
    busIn_read_n_write      = 1'b0;
    busIn_burst_size        = 8'(burst_n);
    busIn_byte_enables      = be_v;
    if (err) push(KR, cyc + 1, 32'd0, 1'b0);
    tick();
    busIn_begin_transaction = 1'b0;
    cnt = 0;
    for (int j = 0; j < nsend; j++) begin
      busIn_data_valid      = 1'b1;
      busIn_address_data    = wdata[j];
      busIn_end_transaction = end_last && (j == nsend - 1);
      accepted = sel && !err && !busIn_end_transaction && (cnt <= burst_n);
      if (accepted) begin
        for (int b = 0; b < 4; b++)
          if (be_v[b]) model_mem[(idx + cnt) & 511][8*b +: 8] = wdata[j][8*b +: 8];
        cnt++;
        if (cnt % 4 == 0) begin
          push(KB, cyc + 1, 32'd0, 1'b0);
          tick();
        end
      end
      tick();
    end
    busIn_data_valid   = 1'b0;
    busIn_address_data = '0;
    if (!end_last) begin
      busIn_end_transaction = 1'b1;
      tick();
    end
    busIn_end_transaction = 1'b0;
    tick();
  endtask

  // abort_beat >= 0: end_transaction while beat abort_beat-1 is shown. reset_beat >= 0: reset during that beat.
  task automatic do_read(int addr, int burst_n, int abort_beat, int reset_beat);
    bit sel;
    bit err;
    int idx;
    int c0;
    int nb;
    sel = (addr < 2048);
    idx = (addr >> 2) & 511;
    err = sel && (idx + burst_n >= 512);
    tick();
    busIn_begin_transaction = 1'b1;
    busIn_address_data      = 32'(addr);
    busIn_read_n_write      = 1'b1;
    busIn_burst_size        = 8'(burst_n);
    c0 = cyc + 1;
    if (sel && err) begin
      push(KR, c0, 32'd0, 1'b0);
    end else if (sel) begin
      nb = (abort_beat >= 0) ? abort_beat : ((reset_beat >= 0) ? reset_beat - 1 : burst_n + 1);
      for (int i = 0; i < nb; i++) push(KD, c0 + 1 + i, model_mem[(idx + i) & 511], 1'b0);
      if (abort_beat >= 0) push(KD, c0 + 1 + nb, model_mem[(idx + nb) & 511], 1'b1);
      if (abort_beat < 0 && reset_beat < 0) push(KE, c0 + burst_n + 2, 32'd0, 1'b0);
    end
    tick();
    busIn_begin_transaction = 1'b0;
    busIn_address_data      = '0;
    busIn_read_n_write      = 1'b0;
    if (abort_beat >= 0) begin
      while (cyc < c0 + abort_beat) tick();
      busIn_end_transaction = 1'b1;
      tick();
      busIn_end_transaction = 1'b0;
    end
    if (reset_beat >= 0) begin
      while (cyc < c0 + reset_beat) tick();
      #2 reset = 1'b0;
      #1 check_outputs_zero("async_reset_outputs");
      tick();
      tick();
      reset = 1'b1;
    end
    while (cyc < c0 + burst_n + 4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    #1 reset = 1'b0;
    #1 check_outputs_zero("reset_state");
    repeat (3) tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) wdata[i] = 32'(i + 1);
    do_write(32, 9, 10, 1'b0, 4'hF);
    do_read(32, 9, -1, -1);

    wdata[0] = 32'h1122_3344;
    do_write(0, 0, 1, 1'b0, 4'hF);
    wdata[0] = 32'hAABB_CCDD;
    do_write(0, 0, 1, 1'b0, 4'b0101);
    do_read(0, 0, -1, -1);

    wdata[0] = 32'hA5A5_0001;
    wdata[1] = 32'hA5A5_0002;
    do_write(4 * 510, 1, 2, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++) wdata[i] = 32'hBAD0_0000 + 32'(i);
    do_write(4 * 510, 2, 3, 1'b0, 4'hF);
    do_read(4 * 510, 1, -1, -1);
    do_read(4 * 510, 2, -1, -1);

    do_read(4 * 512, 0, -1, -1);
    wdata[0] = 32'hBAD0_0800;
    do_write(4 * 512, 0, 1, 1'b0, 4'hF);
    do_read(0, 0, -1, -1);

    for (int i = 0; i < 8; i++) wdata[i] = 32'hC0DE_0000 + 32'(i);
    do_write(400, 7, 8, 1'b0, 4'hF);
    do_read(400, 7, -1, -1);

    wdata[0] = 32'h0000_0CAA;
    do_write(4 * 202, 0, 1, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++) wdata[i] = 32'h0200_0000 + 32'(i);
    do_write(4 * 200, 1, 3, 1'b0, 4'hF);
    do_read(4 * 200, 2, -1, -1);

    wdata[0] = 32'h0000_0301;
    do_write(4 * 301, 0, 1, 1'b0, 4'hF);
    wdata[0] = 32'h0000_300A;
    wdata[1] = 32'h0000_300B;
    do_write(4 * 300, 3, 2, 1'b1, 4'hF);
    do_read(4 * 300, 1, -1, -1);

    do_read(32, 15, 5, -1);
    do_read(32, 3, -1, -1);

    do_read(32, 15, -1, 4);
    do_read(32, 9, -1, -1);

    repeat (5) tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
